// File: rtl/decoder_pkg.sv
// Shared constants and the reference one-hot helper for the select/enable decoder.
package decoder_pkg;

  localparam int DEC_IN_W  = 2;
  localparam int DEC_OUT_W = 1 << DEC_IN_W;

  // Reference decode at the default width; wider builds use the generic path in decoder_core.
  function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] idx,
                                                  input logic                en);
    logic [DEC_OUT_W-1:0] result;
    result = '0;
    if (en) begin
      result[idx] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/decoder_unit_if.sv
// Select/enable request and registered one-hot result for decoder_unit.
interface decoder_unit_if #(
  parameter int IN_W = 2
);
  import decoder_pkg::*;

  localparam int OUT_W = 1 << IN_W;

  logic [IN_W-1:0]  in;
  logic             en;
  logic [OUT_W-1:0] out;

  modport master (
    output in,
    output en,
    input  out
  );

  modport slave (
    input  in,
    input  en,
    output out
  );

endinterface

// File: rtl/decoder_core.sv
// Purely combinational binary-to-one-hot generation gated by enable.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  in_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] out_o
);

  // Equality per output bit guarantees at most one bit can ever be set.
  if (IN_W == DEC_IN_W) begin : g_default_width
    always_comb begin
      out_o = onehot(in_i, en_i);
    end
  end else begin : g_generic_width
    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
      assign out_o[i] = en_i && (in_i == IN_W'(i));
    end
  end

endmodule

// File: rtl/decoder_unit.sv
// Registered one-hot decoder: decoder_core feeds a single output register with synchronous reset.
module decoder_unit
  import decoder_pkg::*;
#(
  parameter int IN_W = DEC_IN_W  // legal range 1..6
) (
  input  logic           clk,
  input  logic           rst,
  decoder_unit_if.slave  bus
);

  localparam int OUT_W = 1 << IN_W;

  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_i  (bus.in),
    .en_i  (bus.en),
    .out_o (out_d)
  );

  // Reset wins over enable; otherwise each edge captures only that edge's decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

  a_onehot0 : assert property (@(posedge clk) $onehot0(out_q));

endmodule

// File: tb/tb_decoder_unit.sv
// Directed bench for decoder_unit at the default width and an IN_W=3 build.
module tb_decoder_unit;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decoder_unit_if #(.IN_W(2)) bus2 ();
  decoder_unit_if #(.IN_W(3)) bus3 ();

  decoder_unit #(.IN_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  decoder_unit #(.IN_W(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [1:0] in;
    logic [3:0] expOut;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drives inputs on the falling edge, then waits until just after the next rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] i);
    @(negedge clk);
    rst     = r;
    bus2.en = e;
    bus2.in = i;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus3(input logic r, input logic e, input logic [2:0] i);
    @(negedge clk);
    rst     = r;
    bus3.en = e;
    bus3.in = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    bus2.en = 1'b0;
    bus2.in = '0;
    bus3.en = 1'b0;
    bus3.in = '0;

    vecs.push_back('{"rst_hold0",   1'b1, 1'b1, 2'b11, 4'b0000});
    vecs.push_back('{"rst_hold1",   1'b1, 1'b1, 2'b11, 4'b0000});
    vecs.push_back('{"rst_release", 1'b0, 1'b1, 2'b11, 4'b1000});
    vecs.push_back('{"sweep_00",    1'b0, 1'b1, 2'b00, 4'b0001});
    vecs.push_back('{"sweep_01",    1'b0, 1'b1, 2'b01, 4'b0010});
    vecs.push_back('{"sweep_10",    1'b0, 1'b1, 2'b10, 4'b0100});
    vecs.push_back('{"sweep_11",    1'b0, 1'b1, 2'b11, 4'b1000});
    vecs.push_back('{"dis_00",      1'b0, 1'b0, 2'b00, 4'b0000});
    vecs.push_back('{"dis_01",      1'b0, 1'b0, 2'b01, 4'b0000});
    vecs.push_back('{"dis_10",      1'b0, 1'b0, 2'b10, 4'b0000});
    vecs.push_back('{"dis_11",      1'b0, 1'b0, 2'b11, 4'b0000});
    vecs.push_back('{"en_toggle",   1'b0, 1'b1, 2'b10, 4'b0100});
    vecs.push_back('{"mid_pre",     1'b0, 1'b1, 2'b00, 4'b0001});
    vecs.push_back('{"mid_rst",     1'b1, 1'b1, 2'b01, 4'b0000});
    vecs.push_back('{"mid_post0",   1'b0, 1'b1, 2'b10, 4'b0100});
    vecs.push_back('{"mid_post1",   1'b0, 1'b1, 2'b11, 4'b1000});

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].in);
      checkOutput(vecs[k].name, {4'b0, bus2.out}, {4'b0, vecs[k].expOut});
    end

    // One-cycle latency: the new select must not show until the following edge.
    applyStimulus(1'b0, 1'b1, 2'b01);
    checkOutput("lat_edgeN", {4'b0, bus2.out}, 8'b0000_0010);
    @(negedge clk);
    bus2.in = 2'b10;
    #1;
    checkOutput("lat_before_edge", {4'b0, bus2.out}, 8'b0000_0010);
    bus2.in = 2'b11;
    #1;
    bus2.in = 2'b00;
    #1;
    bus2.en = 1'b0;
    #1;
    checkOutput("glitch_hold", {4'b0, bus2.out}, 8'b0000_0010);
    bus2.en = 1'b1;
    bus2.in = 2'b10;
    @(posedge clk);
    #1;
    checkOutput("lat_edgeN1", {4'b0, bus2.out}, 8'b0000_0100);

    // Wider build: eight outputs, shares reset with the default instance.
    applyStimulus3(1'b0, 1'b1, 3'b101);
    checkOutput("w3_in101", bus3.out, 8'b0010_0000);
    applyStimulus3(1'b0, 1'b1, 3'b000);
    checkOutput("w3_in000", bus3.out, 8'b0000_0001);
    applyStimulus3(1'b0, 1'b1, 3'b111);
    checkOutput("w3_in111", bus3.out, 8'b1000_0000);
    applyStimulus3(1'b0, 1'b0, 3'b110);
    checkOutput("w3_disabled", bus3.out, 8'b0000_0000);
    applyStimulus3(1'b0, 1'b1, 3'b011);
    checkOutput("w3_in011", bus3.out, 8'b0000_1000);
    applyStimulus3(1'b1, 1'b1, 3'b101);
    checkOutput("w3_reset", bus3.out, 8'b0000_0000);
    applyStimulus3(1'b0, 1'b1, 3'b101);
    checkOutput("w3_after_reset", bus3.out, 8'b0010_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
